// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, a one-entry skid for
// words that arrive while decode stalls, and squashing of stale requests on redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000060
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_address,
  output logic        imem_read,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instruction,
  output logic [6:0]  if_opcode,
  output logic [4:0]  if_rd,
  output logic [2:0]  if_funct3,
  output logic [6:0]  if_funct7
);

  // state   | meaning
  // FETCH   | request at pc in flight; its word goes to IF/ID, or to skid if decode stalls
  // DISCARD | stale request at req_addr in flight; its word is dropped, then refetch from tgt
  // BLOCKED | word parked in skid while decode stalls; no request issued
  typedef enum logic [1:0] {FETCH, DISCARD, BLOCKED} state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx, req_addr, req_addr_nx, tgt, tgt_nx;
  logic        skid_valid, skid_valid_nx;
  logic [31:0] skid_pc, skid_pc_nx, skid_ins, skid_ins_nx;
  logic        valid_nx;
  logic [31:0] if_pc_nx, ins_nx;

  assign imem_read    = rst && (state != BLOCKED);
  assign imem_address = !imem_read ? 32'h0 : ((state == DISCARD) ? req_addr : pc);

  always_comb begin
    state_nx      = state;
    pc_nx         = pc;
    req_addr_nx   = req_addr;
    tgt_nx        = tgt;
    skid_valid_nx = skid_valid;
    skid_pc_nx    = skid_pc;
    skid_ins_nx   = skid_ins;
    valid_nx      = if_valid;
    if_pc_nx      = if_pc;
    ins_nx        = if_instruction;
    case (state)
      FETCH: begin
        if (redirect) begin
          valid_nx = 1'b0;
          if (imem_resp) begin
            pc_nx = redirect_pc;
          end else begin
            req_addr_nx = pc;
            tgt_nx      = redirect_pc;
            state_nx    = DISCARD;
          end
        end else if (imem_resp) begin
          pc_nx = pc + 32'd4;
          if (stall) begin
            skid_valid_nx = 1'b1;
            skid_pc_nx    = pc;
            skid_ins_nx   = imem_rdata;
            state_nx      = BLOCKED;
          end else begin
            valid_nx = 1'b1;
            if_pc_nx = pc;
            ins_nx   = imem_rdata;
          end
        end else if (!stall) begin
          valid_nx = 1'b0;
        end
      end
      DISCARD: begin
        valid_nx = 1'b0;
        if (redirect) tgt_nx = redirect_pc;
        // a redirect landing with the response must win over the older target
        if (imem_resp) begin
          pc_nx    = redirect ? redirect_pc : tgt;
          state_nx = FETCH;
        end
      end
      BLOCKED: begin
        if (redirect) begin
          skid_valid_nx = 1'b0;
          pc_nx         = redirect_pc;
          valid_nx      = 1'b0;
          state_nx      = FETCH;
        end else if (!stall) begin
          valid_nx      = skid_valid;
          if_pc_nx      = skid_pc;
          ins_nx        = skid_ins;
          skid_valid_nx = 1'b0;
          state_nx      = FETCH;
        end
      end
      default: state_nx = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= FETCH;
      pc             <= RESET_PC;
      req_addr       <= 32'h0;
      tgt            <= 32'h0;
      skid_valid     <= 1'b0;
      skid_pc        <= 32'h0;
      skid_ins       <= 32'h0;
      if_valid       <= 1'b0;
      if_pc          <= 32'h0;
      if_instruction <= 32'h0;
      if_opcode      <= 7'h0;
      if_rd          <= 5'h0;
      if_funct3      <= 3'h0;
      if_funct7      <= 7'h0;
    end else begin
      state          <= state_nx;
      pc             <= pc_nx;
      req_addr       <= req_addr_nx;
      tgt            <= tgt_nx;
      skid_valid     <= skid_valid_nx;
      skid_pc        <= skid_pc_nx;
      skid_ins       <= skid_ins_nx;
      if_valid       <= valid_nx;
      if_pc          <= if_pc_nx;
      if_instruction <= ins_nx;
      if_opcode      <= ins_nx[6:0];
      if_rd          <= ins_nx[11:7];
      if_funct3      <= ins_nx[14:12];
      if_funct7      <= ins_nx[31:25];
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed cycle table, reset-in-DISCARD sequence, then
// random stall/redirect traffic against a program-order model with a latency-varying memory.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] imem_address, imem_rdata = 32'h0;
  logic        imem_read, imem_resp = 1'b0;
  logic        if_valid;
  logic [31:0] if_pc, if_instruction;
  logic [6:0]  if_opcode, if_funct7;
  logic [4:0]  if_rd;
  logic [2:0]  if_funct3;

  fetch_stage #(.RESET_PC(32'h00000060)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_address(imem_address), .imem_read(imem_read), .imem_rdata(imem_rdata),
    .imem_resp(imem_resp), .if_valid(if_valid), .if_pc(if_pc), .if_instruction(if_instruction),
    .if_opcode(if_opcode), .if_rd(if_rd), .if_funct3(if_funct3), .if_funct7(if_funct7)
  );

  always #5 clk = ~clk;

  int n_total = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00000013;
  endfunction

  // behavioural memory: samples a request, answers after 1..4 cycles with a one-cycle resp
  logic        mem_auto = 1'b0, mem_busy = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  int          mem_cnt = 0;

  initial forever begin
    @(posedge clk); #1;
    if (mem_auto) begin
      if (!rst) begin
        mem_busy  = 1'b0;
        imem_resp = 1'b0;
      end else begin
        if (imem_resp) begin
          imem_resp = 1'b0;
          mem_busy  = 1'b0;
        end
        if (!mem_busy && imem_read) begin
          mem_addr = imem_address;
          mem_busy = 1'b1;
          mem_cnt  = $urandom_range(1, 4);
        end
        if (mem_busy) begin
          if (mem_cnt <= 1) begin
            imem_resp  = 1'b1;
            imem_rdata = word_of(mem_addr);
          end else begin
            mem_cnt--;
          end
        end
      end
    end
  end

  typedef struct {
    logic        st, rd;
    logic [31:0] rpc;
    logic        rsp;
    logic [31:0] rdat;
    logic        e_read;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc, e_ins;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rpc,
                              input logic rsp, input logic [31:0] rdat, input logic e_read,
                              input logic [31:0] e_addr, input logic e_valid,
                              input logic [31:0] e_pc, input logic [31:0] e_ins);
    vec_t v;
    v.st = st; v.rd = rd; v.rpc = rpc; v.rsp = rsp; v.rdat = rdat;
    v.e_read = e_read; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc; v.e_ins = e_ins;
    return v;
  endfunction

  task automatic chk_zero(input string nm);
    chk({nm, "_read"}, {63'h0, imem_read}, 64'h0);
    chk({nm, "_addr"}, {32'h0, imem_address}, 64'h0);
    chk({nm, "_valid"}, {63'h0, if_valid}, 64'h0);
    chk({nm, "_pc_ins"}, {if_pc, if_instruction}, 64'h0);
    chk({nm, "_fields"}, {42'h0, if_funct7, if_funct3, if_rd, if_opcode}, 64'h0);
  endtask

  vec_t        vt[$];
  logic [31:0] ei, exp_pc, s_pc, s_ins, w, r;
  logic        s_valid;
  logic [21:0] s_fld;
  int          n_deliv;

  localparam logic [31:0] NOP = 32'h00000013, DROP = 32'hDEADBEEF;
  localparam logic [31:0] WA = 32'hAAA00093, WB = 32'h00A30293, WC = 32'h40B50533;
  localparam logic [31:0] WH = 32'hFE0718E3, WI = 32'h0041A023, WJ = 32'h12345678;

  initial begin
    //            st rd rpc        rsp rdata  read addr       valid pc         ins
    vt.push_back(mk(0, 0, 32'h0,   0, 32'h0,  1, 32'h060, 0, 32'h0,   32'h0));
    vt.push_back(mk(0, 0, 32'h0,   1, NOP,    1, 32'h060, 1, 32'h060, NOP));
    vt.push_back(mk(0, 0, 32'h0,   1, NOP,    1, 32'h064, 1, 32'h064, NOP));
    vt.push_back(mk(0, 0, 32'h0,   1, NOP,    1, 32'h068, 1, 32'h068, NOP));
    vt.push_back(mk(1, 0, 32'h0,   1, WA,     1, 32'h06C, 1, 32'h068, NOP));
    vt.push_back(mk(1, 0, 32'h0,   0, 32'h0,  0, 32'h0,   1, 32'h068, NOP));
    vt.push_back(mk(1, 0, 32'h0,   0, 32'h0,  0, 32'h0,   1, 32'h068, NOP));
    vt.push_back(mk(0, 0, 32'h0,   0, 32'h0,  0, 32'h0,   1, 32'h06C, WA));
    vt.push_back(mk(0, 0, 32'h0,   0, 32'h0,  1, 32'h070, 0, 32'h0,   32'h0));
    vt.push_back(mk(0, 1, 32'h100, 0, 32'h0,  1, 32'h070, 0, 32'h0,   32'h0));
    vt.push_back(mk(0, 0, 32'h0,   0, 32'h0,  1, 32'h070, 0, 32'h0,   32'h0));
    vt.push_back(mk(0, 0, 32'h0,   0, 32'h0,  1, 32'h070, 0, 32'h0,   32'h0));
    vt.push_back(mk(0, 0, 32'h0,   1, DROP,   1, 32'h070, 0, 32'h0,   32'h0));
    vt.push_back(mk(0, 0, 32'h0,   1, WB,     1, 32'h100, 1, 32'h100, WB));
    vt.push_back(mk(0, 1, 32'h200, 1, DROP,   1, 32'h104, 0, 32'h0,   32'h0));
    vt.push_back(mk(0, 0, 32'h0,   1, WC,     1, 32'h200, 1, 32'h200, WC));
    vt.push_back(mk(1, 1, 32'h300, 0, 32'h0,  1, 32'h204, 0, 32'h0,   32'h0));
    vt.push_back(mk(0, 1, 32'h340, 0, 32'h0,  1, 32'h204, 0, 32'h0,   32'h0));
    vt.push_back(mk(0, 0, 32'h0,   1, DROP,   1, 32'h204, 0, 32'h0,   32'h0));
    vt.push_back(mk(0, 0, 32'h0,   1, WH,     1, 32'h340, 1, 32'h340, WH));
    vt.push_back(mk(1, 0, 32'h0,   1, WI,     1, 32'h344, 1, 32'h340, WH));
    vt.push_back(mk(1, 1, 32'h400, 0, 32'h0,  0, 32'h0,   0, 32'h0,   32'h0));
    vt.push_back(mk(0, 0, 32'h0,   1, WJ,     1, 32'h400, 1, 32'h400, WJ));
    vt.push_back(mk(0, 0, 32'h0,   0, 32'h0,  1, 32'h404, 0, 32'h0,   32'h0));
    vt.push_back(mk(0, 1, 32'h500, 0, 32'h0,  1, 32'h404, 0, 32'h0,   32'h0));

    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      stall = vt[i].st; redirect = vt[i].rd; redirect_pc = vt[i].rpc;
      imem_resp = vt[i].rsp; imem_rdata = vt[i].rdat;
      #1;
      chk($sformatf("row%0d_read", i), {63'h0, imem_read}, {63'h0, vt[i].e_read});
      if (vt[i].e_read) chk($sformatf("row%0d_addr", i), {32'h0, imem_address}, {32'h0, vt[i].e_addr});
      @(posedge clk); @(negedge clk);
      chk($sformatf("row%0d_valid", i), {63'h0, if_valid}, {63'h0, vt[i].e_valid});
      if (vt[i].e_valid) begin
        ei = vt[i].e_ins;
        chk($sformatf("row%0d_pc_ins", i), {if_pc, if_instruction}, {vt[i].e_pc, ei});
        chk($sformatf("row%0d_fields", i), {42'h0, if_funct7, if_funct3, if_rd, if_opcode},
            {42'h0, ei[31:25], ei[14:12], ei[11:7], ei[6:0]});
      end
    end

    // reset pulsed while the DUT is discarding the request for 404
    stall = 1'b0; redirect = 1'b0; imem_resp = 1'b0;
    rst = 1'b0;
    #1 chk_zero("rst_mid_discard");
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    chk("restart_read", {63'h0, imem_read}, 64'h1);
    chk("restart_addr", {32'h0, imem_address}, 64'h60);
    imem_resp = 1'b1; imem_rdata = WB;
    @(posedge clk); @(negedge clk);
    imem_resp = 1'b0;
    chk("restart_deliver", {31'h0, if_valid, if_pc}, {31'h0, 1'b1, 32'h60});

    // random traffic against the program-order model
    rst = 1'b0; mem_auto = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_pc = 32'h60;
    n_deliv = 0;
    for (int c = 0; c < 3000; c++) begin
      s_valid = if_valid; s_pc = if_pc; s_ins = if_instruction;
      s_fld = {if_funct7, if_funct3, if_rd, if_opcode};
      if (mem_busy && imem_read) chk("rand_addr_stable", {32'h0, imem_address}, {32'h0, mem_addr});
      stall = ($urandom_range(0, 9) < 3);
      redirect = ($urandom_range(0, 15) == 0);
      r = $urandom;
      redirect_pc = r & 32'hFFFF_FFFC;
      @(posedge clk); @(negedge clk);
      if (redirect) begin
        chk("rand_redirect_kill", {63'h0, if_valid}, 64'h0);
        exp_pc = redirect_pc;
      end else if (stall) begin
        chk("rand_stall_hold", {if_pc, if_instruction}, {s_pc, s_ins});
        chk("rand_stall_valid", {63'h0, if_valid}, {63'h0, s_valid});
      end else if (s_valid) begin
        w = word_of(exp_pc);
        chk("rand_order_pc", {32'h0, s_pc}, {32'h0, exp_pc});
        chk("rand_word", {32'h0, s_ins}, {32'h0, w});
        chk("rand_fields", {42'h0, s_fld}, {42'h0, w[31:25], w[14:12], w[11:7], w[6:0]});
        exp_pc = exp_pc + 32'd4;
        n_deliv++;
      end
    end
    chk("rand_progress", {63'h0, n_deliv > 100}, 64'h1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h00000060, PC fetched first after reset.
REQ-002 SHALL have ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- stall  in  1  decode cannot accept a new instruction; the IF/ID register holds.
- redirect  in  1  taken branch/jump resolved downstream; flush and refetch.
- redirect_pc  in  32  target PC, valid while redirect=1.
- imem_address  out  32  instruction memory read address.
- imem_read  out  1  instruction memory read request.
- imem_rdata  in  32  instruction word, valid while imem_resp=1.
- imem_resp  in  1  one-cycle read completion.
- if_valid  out  1  IF/ID holds a live instruction; drives the decode commit_in.
- if_pc  out  32  PC of the held instruction.
- if_instruction  out  32  held instruction word.
- if_opcode  out  7  if_instruction[6:0].
- if_rd  out  5  if_instruction[11:7].
- if_funct3  out  3  if_instruction[14:12].
- if_funct7  out  7  if_instruction[31:25].

Function
REQ-003 SHALL keep internal registers: pc (next fetch address), req_addr (address of the outstanding request), tgt (latched redirect target), skid (buffered word plus its PC), and state in {FETCH, DISCARD, BLOCKED}.
REQ-004 SHALL drive imem_read=1 in FETCH and DISCARD, and 0 in BLOCKED and while rst=0.
REQ-005 SHALL drive imem_address=pc in FETCH and imem_address=req_addr in DISCARD, holding it stable until imem_resp.
REQ-006 SHALL, in FETCH with imem_resp=1, redirect=0 and stall=0: load the IF/ID register with {pc, imem_rdata}, set if_valid=1, set pc=pc+4 (mod 2^32), stay in FETCH, and issue the next request in the following cycle.
REQ-007 SHALL, in FETCH with imem_resp=1, redirect=0 and stall=1: capture {pc, imem_rdata} into skid, set pc=pc+4, go to BLOCKED, and leave IF/ID unchanged.
REQ-008 SHALL, in BLOCKED with stall=0 and redirect=0: move skid into IF/ID, set if_valid=1, and go to FETCH.
REQ-009 SHALL, in FETCH with imem_resp=0 and stall either value, leave IF/ID unchanged if stall=1; if stall=0, set if_valid=0 (bubble).
REQ-010 SHALL, on redirect=1 in FETCH with imem_resp=0: latch req_addr=pc and tgt=redirect_pc, then go to DISCARD.
REQ-011 SHALL, on redirect=1 in FETCH with imem_resp=1: drop the word, set pc=redirect_pc, and stay in FETCH.
REQ-012 SHALL, on redirect=1 in BLOCKED: invalidate skid, set pc=redirect_pc, and go to FETCH.
REQ-013 SHALL, in DISCARD on imem_resp=1: drop the word, set pc=tgt, and go to FETCH; it stays in DISCARD otherwise.
REQ-014 SHALL, in DISCARD on a further redirect=1: overwrite tgt with the newest redirect_pc, taking the last one.
REQ-015 SHALL give redirect priority over stall: on redirect=1, if_valid becomes 0 at the next edge regardless of stall.
REQ-016 SHALL never deliver a fetched word whose address differs from the current program order; at most one request is outstanding.
REQ-017 SHALL keep if_opcode, if_rd, if_funct3 and if_funct7 registered together with if_instruction, always consistent with it.
REQ-018 SHALL keep if_* outputs stable whenever stall=1 and redirect=0.

Reset
REQ-019 SHALL, while rst=0, immediately force: state=FETCH, pc=RESET_PC, req_addr=0, tgt=0, skid invalid, if_valid=0, and if_pc, if_instruction and all decoded fields=0.
REQ-020 SHALL, with reset asserted mid-request, abandon the request; the first request after release uses RESET_PC.

Verification
REQ-021 SHALL be covered by: release rst, memory responds in 1 cycle with 32'h00000013 each fetch -> addresses 60,64,68; if_valid=1 from the cycle after the first resp; if_pc follows 60,64,68.
REQ-022 SHALL be covered by: stall=1 held 3 cycles while the resp for 64 arrives -> imem_read=0 in BLOCKED; if_pc=60 held; after stall drops, if_pc=64 next edge, and the next fetch is 68.
REQ-023 SHALL be covered by: redirect=1, redirect_pc=32'h00000100, while the request for 68 is pending with a 4-cycle latency -> imem_address stays 68 until resp; the word is dropped; the next fetch is 100; if_valid=0 in between.
REQ-024 SHALL be covered by: redirect and imem_resp in the same cycle -> the word is not delivered, the next imem_address=redirect_pc, and the state stays FETCH.
REQ-025 SHALL be covered by: redirect=1 together with stall=1 -> if_valid=0 next edge.
REQ-026 SHALL be covered by: rst pulsed low mid-DISCARD -> all outputs are zero at once, and the fetch restarts at 60.
